train_sequencer: RTL
====================

TRAIN_SEQUENCER -- requirements
Module: train_sequencer

Interface
REQ-001 Parameter: OUTPUT_SZ, default 10, number of output classes from the tile.
REQ-002 Parameter: TIMEOUT, default 2048, maximum cycles to wait for tile_done per image.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: run  in  1  pulse that starts a pass; sampled only in IDLE.
REQ-006 Port: train  in  1  sampled with run; 1 = training pass (start_bp), 0 = inference pass (start_fp).
REQ-007 Port: num_images  in  16  images in the pass; sampled with run.
REQ-008 Port: abort  in  1  terminates the pass from any state.
REQ-009 Port: img_req  out  1  request to the image loader for image img_idx.
REQ-010 Port: img_idx  out  16  index of the current image, 0-based.
REQ-011 Port: img_ack  in  1  loader response; image and label are valid this cycle.
REQ-012 Port: label  in  8  class label; sampled when img_req && img_ack.
REQ-013 Port: start_fp, start_bp  out  1 each  single-cycle tile start pulses.
REQ-014 Port: tile_done  in  1  tile completion pulse.
REQ-015 Port: result  in  OUTPUT_SZ x 32  tile outputs; sampled when tile_done is high.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: pass_done  out  1  single-cycle pulse when a pass completes normally.
REQ-018 Port: correct_cnt  out  16  number of correctly classified images in the current or last pass.
REQ-019 Port: err_timeout  out  1  sticky flag indicating the tile did not finish within TIMEOUT.

Function
REQ-020 The FSM states SHALL be IDLE, FETCH, START, WAIT, SCORE, DONE and ERR.
REQ-021 IDLE: on run, the block SHALL latch train and num_images, clear img_idx, correct_cnt and err_timeout, and go to FETCH, or to DONE if num_images==0.
REQ-022 FETCH: img_req SHALL be high; on img_ack the block SHALL latch label and go to START.
- An ack in the first FETCH cycle is valid.
REQ-023 START: the block SHALL pulse start_bp if train is latched, otherwise start_fp, for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-024 WAIT: the block SHALL count cycles.
- On tile_done: register result and go to SCORE.
- If the count reaches TIMEOUT-1 without tile_done: set err_timeout and go to ERR.
- tile_done in the same cycle as the limit: tile_done wins.
REQ-025 SCORE: the block SHALL compute the argmax of the registered result as signed 32-bit values, with the lowest index winning ties.
- If argmax == latched label: increment correct_cnt.
- Increment img_idx.
- Go to DONE if img_idx+1 == num_images, otherwise go to FETCH.
REQ-026 A latched label >= OUTPUT_SZ SHALL always count as incorrect.
REQ-027 correct_cnt SHALL saturate at 16'hFFFF; img_idx SHALL not wrap within a pass.
REQ-028 DONE: pass_done SHALL be high for one cycle, then the FSM returns to IDLE.
REQ-029 ERR: the FSM SHALL return to IDLE on the next cycle with no pass_done.
- err_timeout holds until the next accepted run.
REQ-030 abort in any non-IDLE state SHALL force IDLE on the next edge, with no pass_done and no start pulse.
- correct_cnt and img_idx hold their values.
- abort overrides every other transition in the same cycle.
REQ-031 run while busy SHALL be ignored.
REQ-032 tile_done outside WAIT and img_ack outside FETCH SHALL be ignored.
REQ-033 Latency SHALL be as follows:
- run at edge N → img_req high after edge N+1.
- img_ack at edge M → start pulse after edge M+1.
- tile_done at edge K → FETCH or DONE after edge K+2.

Reset
REQ-034 While rst_n is low, the block SHALL be in IDLE with all outputs 0, img_idx=0 and correct_cnt=0.
REQ-035 Reset asserted mid-pass SHALL abandon the pass immediately, with no pulses emitted.

Verification
REQ-036 run, train=0, num_images=3, loader acks immediately, labels 2,5,7, tile answers argmax 2,4,7 → three start_fp pulses, no start_bp, pass_done once, correct_cnt=2.
REQ-037 run with num_images=0 → pass_done on the second cycle after run, no img_req, correct_cnt=0.
REQ-038 train=1, tile never asserts tile_done, TIMEOUT=16 → one start_bp, err_timeout=1 sixteen cycles later, IDLE, no pass_done.
REQ-039 result with all elements equal and label=0 → counted correct; label=12 with any result → counted incorrect.
REQ-040 abort asserted during WAIT of image 1 of 4 → IDLE next cycle, img_idx=1, no pass_done; a subsequent run restarts with img_idx=0 and correct_cnt=0.
REQ-041 rst_n pulsed low during FETCH → img_req drops asynchronously, busy=0, and the next run behaves as it does from power-up.

Source files
------------

// File: rtl/train_sequencer.sv
// Pass sequencer for a classifier tile: fetches each image, starts the tile,
// scores its argmax against the label and reports timeouts.
module train_sequencer #(
    parameter int unsigned OUTPUT_SZ = 10,
    parameter int unsigned TIMEOUT   = 2048
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic                      train,
    input  logic [15:0]               num_images,
    input  logic                      abort,
    output logic                      img_req,
    output logic [15:0]               img_idx,
    input  logic                      img_ack,
    input  logic [7:0]                label,
    output logic                      start_fp,
    output logic                      start_bp,
    input  logic                      tile_done,
    input  logic [OUTPUT_SZ-1:0][31:0] result,
    output logic                      busy,
    output logic                      pass_done,
    output logic [15:0]               correct_cnt,
    output logic                      err_timeout
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned IdxW = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StWait,
        StScore,
        StDone,
        StErr
    } state_e;

    state_e                       state_q, state_d;
    logic                         train_q, train_d;
    logic [15:0]                  num_q, num_d;
    logic [15:0]                  idx_q, idx_d;
    logic [15:0]                  corr_q, corr_d;
    logic                         err_q, err_d;
    logic [7:0]                   label_q, label_d;
    logic [CntW-1:0]              tmo_q, tmo_d;
    logic [OUTPUT_SZ-1:0][31:0]   res_q, res_d;

    logic [IdxW-1:0]              best_idx;
    logic signed [31:0]           best_val;
    logic                         hit;
    logic                         last_img;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            train_q <= 1'b0;
            num_q   <= '0;
            idx_q   <= '0;
            corr_q  <= '0;
            err_q   <= 1'b0;
            label_q <= '0;
            tmo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            train_q <= train_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            corr_q  <= corr_d;
            err_q   <= err_d;
            label_q <= label_d;
            tmo_q   <= tmo_d;
            res_q   <= res_d;
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = $signed(res_q[0]);
        for (int unsigned i = 1; i < OUTPUT_SZ; i++) begin
            if ($signed(res_q[i]) > best_val) begin
                best_val = $signed(res_q[i]);
                best_idx = IdxW'(i);
            end
        end
    end

    assign hit      = ({24'd0, label_q} < OUTPUT_SZ) && (32'(best_idx) == {24'd0, label_q});
    assign last_img = (({1'b0, idx_q} + 17'd1) == {1'b0, num_q});

    always_comb begin
        state_d = state_q;
        train_d = train_q;
        num_d   = num_q;
        idx_d   = idx_q;
        corr_d  = corr_q;
        err_d   = err_q;
        label_d = label_q;
        tmo_d   = tmo_q;
        res_d   = res_q;

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run) begin
                        train_d = train;
                        num_d   = num_images;
                        idx_d   = '0;
                        corr_d  = '0;
                        err_d   = 1'b0;
                        state_d = (num_images == 16'd0) ? StDone : StFetch;
                    end
                end
                StFetch: begin
                    if (img_ack) begin
                        label_d = label;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    tmo_d   = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (tile_done) begin
                        res_d   = result;
                        state_d = StScore;
                    end else if (tmo_q == TmoLast) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                StScore: begin
                    if (hit && (corr_q != 16'hFFFF)) begin
                        corr_d = corr_q + 16'd1;
                    end
                    if (idx_q != 16'hFFFF) begin
                        idx_d = idx_q + 16'd1;
                    end
                    state_d = last_img ? StDone : StFetch;
                end
                StDone:  state_d = StIdle;
                StErr:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Pulses are gated by abort so an aborted cycle never emits one.
    assign img_req     = (state_q == StFetch);
    assign start_fp    = (state_q == StStart) && !train_q && !abort;
    assign start_bp    = (state_q == StStart) && train_q && !abort;
    assign pass_done   = (state_q == StDone) && !abort;
    assign busy        = (state_q != StIdle);
    assign img_idx     = idx_q;
    assign correct_cnt = corr_q;
    assign err_timeout = err_q;

endmodule
